// File: rtl/notification_arbiter_if.sv
// Bundle of requester-side and downstream-side signals of the notification arbiter.
interface notification_arbiter_if #(
   parameter int unsigned NUM_REQ            = 2,
   parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
   parameter int unsigned CHANNEL_ADDR_WIDTH = 34,
   parameter int unsigned BEATS              = 4,
   parameter int unsigned QUEUE_LENGTH       = 8
) ();
   localparam int unsigned OFFW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CRW  = $clog2(QUEUE_LENGTH + 1);
   localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ*CHANNEL_ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*C_S_AXI_ID_WIDTH-1:0]   req_id;
   logic [NUM_REQ*OFFW-1:0]               req_offset;
   logic [NUM_REQ-1:0]                    req_valid;
   logic [NUM_REQ-1:0]                    req_ready;

   logic [CHANNEL_ADDR_WIDTH-1:0]         availability_notification_addr;
   logic [C_S_AXI_ID_WIDTH-1:0]           availability_notification_id;
   logic [OFFW-1:0]                       availability_notification_offset;
   logic                                  availability_notification_valid;

   logic                                  transaction_done;
   logic [CRW-1:0]                        credits;
   logic [GW-1:0]                         last_grant;
   logic                                  overflow_err;

   // Requesters and the downstream queue side.
   modport master (
      output req_addr, req_id, req_offset, req_valid, transaction_done,
      input  req_ready, availability_notification_addr, availability_notification_id,
             availability_notification_offset, availability_notification_valid,
             credits, last_grant, overflow_err
   );

   // The arbiter itself.
   modport slave (
      input  req_addr, req_id, req_offset, req_valid, transaction_done,
      output req_ready, availability_notification_addr, availability_notification_id,
             availability_notification_offset, availability_notification_valid,
             credits, last_grant, overflow_err
   );
endinterface

// File: rtl/notification_arbiter.sv
// Round-robin arbiter that forwards one buffered line-availability notification
// per cycle into a credit-limited downstream queue.
module notification_arbiter #(
   parameter int unsigned NUM_REQ            = 2,
   parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
   parameter int unsigned CHANNEL_ADDR_WIDTH = 34,
   parameter int unsigned BEATS              = 4,
   parameter int unsigned QUEUE_LENGTH       = 8
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   notification_arbiter_if.slave bus
);
   localparam int unsigned AW   = CHANNEL_ADDR_WIDTH;
   localparam int unsigned IW   = C_S_AXI_ID_WIDTH;
   localparam int unsigned OFFW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CRW  = $clog2(QUEUE_LENGTH + 1);
   localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic            r_full [NUM_REQ];
   logic [AW-1:0]   r_addr [NUM_REQ];
   logic [IW-1:0]   r_id   [NUM_REQ];
   logic [OFFW-1:0] r_off  [NUM_REQ];

   logic [AW-1:0]   r_na_addr;
   logic [IW-1:0]   r_na_id;
   logic [OFFW-1:0] r_na_off;
   logic            r_na_valid;
   logic [CRW-1:0]  r_credits;
   logic [GW-1:0]   r_last;
   logic            r_ovf;

   logic [GW-1:0]   w_gidx;
   logic            w_found;
   logic            w_grant;
   int              w_idx;

   // Round-robin pick: first full buffer after the last granted index.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_idx   = 0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         w_idx = (int'(r_last) + k) % int'(NUM_REQ);
         if (!w_found && r_full[GW'(w_idx)]) begin
            w_found = 1'b1;
            w_gidx  = GW'(w_idx);
         end
      end
      w_grant = w_found && (r_credits != '0);
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
      assign bus.req_ready[gi] = ~r_full[gi];

      // Single-entry buffer: load when empty, drain on its own grant.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            r_full[gi] <= 1'b0;
            r_addr[gi] <= '0;
            r_id[gi]   <= '0;
            r_off[gi]  <= '0;
         end else if (!r_full[gi]) begin
            if (bus.req_valid[gi]) begin
               r_full[gi] <= 1'b1;
               r_addr[gi] <= bus.req_addr[gi*AW +: AW];
               r_id[gi]   <= bus.req_id[gi*IW +: IW];
               r_off[gi]  <= bus.req_offset[gi*OFFW +: OFFW];
            end
         end else if (w_grant && (w_gidx == GW'(gi))) begin
            r_full[gi] <= 1'b0;
         end
      end
   end

   // Notification output register, grant pointer and downstream credit tracking.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_na_valid <= 1'b0;
         r_na_addr  <= '0;
         r_na_id    <= '0;
         r_na_off   <= '0;
         r_credits  <= CRW'(QUEUE_LENGTH);
         r_last     <= GW'(NUM_REQ - 1);
         r_ovf      <= 1'b0;
      end else begin
         r_na_valid <= w_grant;
         if (w_grant) begin
            r_na_addr <= r_addr[w_gidx];
            r_na_id   <= r_id[w_gidx];
            r_na_off  <= r_off[w_gidx];
            r_last    <= w_gidx;
         end
         if (w_grant && !bus.transaction_done) begin
            r_credits <= r_credits - CRW'(1);
         end else if (!w_grant && bus.transaction_done) begin
            // A pop with the queue already empty is a protocol error, not a credit.
            if (r_credits == CRW'(QUEUE_LENGTH)) begin
               r_ovf <= 1'b1;
            end else begin
               r_credits <= r_credits + CRW'(1);
            end
         end
      end
   end

   assign bus.availability_notification_addr   = r_na_addr;
   assign bus.availability_notification_id     = r_na_id;
   assign bus.availability_notification_offset = r_na_off;
   assign bus.availability_notification_valid  = r_na_valid;
   assign bus.credits                          = r_credits;
   assign bus.last_grant                       = r_last;
   assign bus.overflow_err                     = r_ovf;
endmodule
